fpu_addsub_pipe: RTL and testbench

- Parametrised successor to the team's single-shot 32-bit custom-float adder.
- Adds or subtracts two custom floats of format {sign, EXP_W exponent, MAN_W fraction} under a valid/ready handshake.
- Aligns exponents, normalises, and rounds to nearest-even using guard/round/sticky bits.
- Sits between the operand register file and the result collector; one operation in flight at a time.

---
 rtl/fpu_addsub_pipe.sv | 232 +++++++++++++++++++++++
 tb/tb_fpu_addsub_pipe.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_pipe.sv
// fpu_addsub_pipe: multi-cycle adder/subtractor for the {sign, exponent, fraction}
// custom float, with round-to-nearest-even and a one-hot result status.
// One operation is in flight at a time, under a valid/ready handshake on both sides.
module fpu_addsub_pipe #(
  parameter int EXP_W = 6,
  parameter int MAN_W = 25,
  parameter int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clock100KHz,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_A_in,
  input  logic [W-1:0] op_B_in,
  input  logic         op_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] data_out,
  output logic [3:0]   status_out
);

  // Working mantissa field: hidden bit, fraction, then guard/round/sticky.
  localparam int F = MAN_W + 4;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);
  localparam logic [EXP_W-1:0] EXP_TOP = EXP_MAX - EXP_ONE;
  localparam logic [EXP_W-1:0] D_MAX   = EXP_W'(MAN_W + 3);

  localparam logic [3:0] ST_UNDER = 4'b1000;
  localparam logic [3:0] ST_OVER  = 4'b0100;
  localparam logic [3:0] ST_INEX  = 4'b0010;
  localparam logic [3:0] ST_EXACT = 4'b0001;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  state_t state;

  // Captured operands (B already carries the effective sign for subtraction).
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;

  // Aligned operands, running sum and result exponent/sign.
  logic             sign_big;
  logic             sign_small;
  logic             sign_r;
  logic             align_sticky;
  logic [EXP_W-1:0] exp_r;
  logic [F-1:0]     man_big;
  logic [F-1:0]     man_small;
  logic [F:0]       sum;

  // Alignment datapath signals.
  logic [EXP_W-1:0] exp_a;
  logic [EXP_W-1:0] exp_b;
  logic [EXP_W-1:0] exp_big;
  logic [EXP_W-1:0] exp_small;
  logic [EXP_W-1:0] exp_diff;
  logic [MAN_W-1:0] frac_big;
  logic [MAN_W-1:0] frac_small;
  logic             sgn_big_c;
  logic             sgn_small_c;
  logic [F-1:0]     big_field;
  logic [F-1:0]     small_field;
  logic [F-1:0]     small_shifted;
  logic [2*F-1:0]   small_wide;

  // Rounding datapath signals.
  logic             round_inc;
  logic             round_carry;
  logic             round_inexact;
  logic             round_overflow;
  logic [MAN_W+1:0] rounded;
  logic [MAN_W-1:0] frac_round;
  logic [EXP_W-1:0] exp_round;

  assign exp_a = op_a[W-2 -: EXP_W];
  assign exp_b = op_b[W-2 -: EXP_W];

  // Pick the larger-exponent operand and shift the other right, folding lost bits into sticky.
  always_comb begin
    if (exp_a >= exp_b) begin
      sgn_big_c   = op_a[W-1];
      exp_big     = exp_a;
      frac_big    = op_a[MAN_W-1:0];
      sgn_small_c = op_b[W-1];
      exp_small   = exp_b;
      frac_small  = op_b[MAN_W-1:0];
    end else begin
      sgn_big_c   = op_b[W-1];
      exp_big     = exp_b;
      frac_big    = op_b[MAN_W-1:0];
      sgn_small_c = op_a[W-1];
      exp_small   = exp_a;
      frac_small  = op_a[MAN_W-1:0];
    end
    exp_diff    = exp_big - exp_small;
    big_field   = {(exp_big != '0), frac_big, 3'b000};
    small_field = {(exp_small != '0), frac_small, 3'b000};
    small_wide  = {small_field, {F{1'b0}}} >> exp_diff;
    if (exp_diff > D_MAX) begin
      small_shifted    = '0;
      small_shifted[0] = |small_field;
    end else begin
      small_shifted    = small_wide[2*F-1:F];
      small_shifted[0] = small_wide[F] | (|small_wide[F-1:0]);
    end
  end

  // Nearest-even rounding of the normalised sum, including the mantissa-carry renormalise.
  always_comb begin
    round_inc      = sum[2] && (sum[1] || sum[0] || sum[3]);
    rounded        = {1'b0, sum[F-1:3]} + {{(MAN_W+1){1'b0}}, round_inc};
    round_carry    = rounded[MAN_W+1];
    frac_round     = round_carry ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
    exp_round      = round_carry ? exp_r + EXP_ONE : exp_r;
    round_overflow = (exp_round == EXP_MAX);
    round_inexact  = (|sum[2:0]) || align_sticky;
  end

  // Control FSM and all datapath registers, with registered handshake and result outputs.
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      data_out     <= '0;
      status_out   <= '0;
      op_a         <= '0;
      op_b         <= '0;
      sign_big     <= 1'b0;
      sign_small   <= 1'b0;
      sign_r       <= 1'b0;
      align_sticky <= 1'b0;
      exp_r        <= '0;
      man_big      <= '0;
      man_small    <= '0;
      sum          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a     <= op_A_in;
            op_b     <= {op_B_in[W-1] ^ op_sub, op_B_in[W-2:0]};
            in_ready <= 1'b0;
            state    <= ALIGN;
          end
        end
        ALIGN: begin
          sign_big     <= sgn_big_c;
          sign_small   <= sgn_small_c;
          exp_r        <= exp_big;
          man_big      <= big_field;
          man_small    <= small_shifted;
          align_sticky <= small_shifted[0];
          state        <= ADD;
        end
        ADD: begin
          if (sign_big == sign_small) begin
            sum    <= {1'b0, man_big} + {1'b0, man_small};
            sign_r <= sign_big;
          end else if (man_big >= man_small) begin
            sum    <= {1'b0, man_big - man_small};
            sign_r <= sign_big;
          end else begin
            sum    <= {1'b0, man_small - man_big};
            sign_r <= sign_small;
          end
          state <= NORM;
        end
        NORM: begin
          if (sum[F]) begin
            if (exp_r >= EXP_TOP) begin
              data_out   <= '0;
              status_out <= ST_OVER;
              out_valid  <= 1'b1;
              state      <= DONE;
            end else begin
              sum   <= {1'b0, sum[F:2], sum[1] | sum[0]};
              exp_r <= exp_r + EXP_ONE;
              state <= ROUND;
            end
          end else if (sum == '0) begin
            data_out   <= '0;
            status_out <= align_sticky ? ST_INEX : ST_EXACT;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else if (exp_r == EXP_MAX) begin
            data_out   <= '0;
            status_out <= ST_OVER;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else if (!sum[F-1]) begin
            if (exp_r <= EXP_ONE) begin
              data_out   <= '0;
              status_out <= ST_UNDER;
              out_valid  <= 1'b1;
              state      <= DONE;
            end else begin
              sum   <= {sum[F-1:0], 1'b0};
              exp_r <= exp_r - EXP_ONE;
            end
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          if (round_overflow) begin
            data_out   <= '0;
            status_out <= ST_OVER;
          end else begin
            data_out   <= {sign_r, exp_round, frac_round};
            status_out <= round_inexact ? ST_INEX : ST_EXACT;
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// tb_fpu_addsub_pipe: directed vectors with hand-computed results, checked by a
// scoreboard queue that a separate monitor drains whenever a result is presented.
`timescale 1ns/1ps
module tb_fpu_addsub_pipe;

  localparam int W = 32;

  logic         clock100KHz = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_A_in = '0;
  logic [W-1:0] op_B_in = '0;
  logic         op_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] data_out;
  logic [3:0]   status_out;

  typedef struct {
    logic [W-1:0] data;
    logic [3:0]   status;
    int           lat;
    string        name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cycle = 0;
  int   cap_cycle = 0;
  int   first_cycle = 0;
  bit   valid_seen = 1'b0;

  fpu_addsub_pipe dut (
    .clock100KHz(clock100KHz),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op_A_in(op_A_in),
    .op_B_in(op_B_in),
    .op_sub(op_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out(data_out),
    .status_out(status_out)
  );

  // Free-running clock.
  always #5 clock100KHz = ~clock100KHz;

  // Cycle counter used to measure capture-to-valid latency.
  always @(posedge clock100KHz) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic sub, input logic [W-1:0] ed, input logic [3:0] es,
                               input int el, input bit expect_it);
    exp_t e;
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clock100KHz); #1;
      guard++;
    end
    if (!in_ready) begin
      checkOutput({name, "_in_ready_timeout"}, {31'b0, in_ready}, 32'd1);
      return;
    end
    op_A_in  = a;
    op_B_in  = b;
    op_sub   = sub;
    in_valid = 1'b1;
    if (expect_it) begin
      e.data   = ed;
      e.status = es;
      e.lat    = el;
      e.name   = name;
      sb.push_back(e);
    end
    @(posedge clock100KHz); #1;
    cap_cycle = cycle;
    in_valid  = 1'b0;
    op_A_in   = $urandom;
    op_B_in   = $urandom;
    op_sub    = 1'($urandom_range(0, 1));
  endtask

  task automatic waitDrain(input string name);
    int guard;
    guard = 0;
    while ((sb.size() != 0 || !in_ready) && guard < 200) begin
      @(posedge clock100KHz); #1;
      guard++;
    end
    if (sb.size() != 0 || !in_ready)
      checkOutput({name, "_drain_timeout"}, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: compares each presented result against the scoreboard head and checks hold-stability.
  always @(negedge clock100KHz) begin
    if (reset && out_valid) begin
      if (!valid_seen) begin
        valid_seen  = 1'b1;
        first_cycle = cycle;
      end
      if (sb.size() == 0) begin
        checkOutput("unexpected_result", data_out, 32'hxxxx_xxxx);
      end else if (out_ready) begin
        mon_e = sb.pop_front();
        checkOutput({mon_e.name, "_data"}, data_out, mon_e.data);
        checkOutput({mon_e.name, "_status"}, {28'b0, status_out}, {28'b0, mon_e.status});
        if (mon_e.lat >= 0)
          checkOutput({mon_e.name, "_latency"}, 32'(first_cycle - cap_cycle), 32'(mon_e.lat));
        valid_seen = 1'b0;
      end else begin
        checkOutput({sb[0].name, "_hold_data"}, data_out, sb[0].data);
        checkOutput({sb[0].name, "_hold_status"}, {28'b0, status_out}, {28'b0, sb[0].status});
        checkOutput({sb[0].name, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
      end
    end
  end

  // Directed stimulus sequence.
  initial begin
    int guard;
    repeat (3) @(posedge clock100KHz);
    #1;
    checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_data", data_out, 32'd0);
    checkOutput("reset_status", {28'b0, status_out}, 32'd0);
    reset = 1'b1;
    @(posedge clock100KHz); #1;

    applyStimulus("one_plus_two",  32'h3E000000, 32'h40000000, 1'b0, 32'h41000000, 4'b0001, 4, 1'b1);
    applyStimulus("one_minus_one", 32'h3E000000, 32'h3E000000, 1'b1, 32'h00000000, 4'b0001, -1, 1'b1);
    applyStimulus("tie_even",      32'h3E000000, 32'h0A000000, 1'b0, 32'h3E000000, 4'b0010, 4, 1'b1);
    applyStimulus("overflow",      32'h7DFFFFFF, 32'h7DFFFFFF, 1'b0, 32'h00000000, 4'b0100, -1, 1'b1);
    applyStimulus("underflow",     32'h02000001, 32'h02000000, 1'b1, 32'h00000000, 4'b1000, -1, 1'b1);
    applyStimulus("long_norm",     32'h3E000001, 32'h3E000000, 1'b1, 32'h0C000000, 4'b0001, 29, 1'b1);
    applyStimulus("tie_odd_up",    32'h3E000001, 32'h0A000000, 1'b0, 32'h3E000002, 4'b0010, 4, 1'b1);
    applyStimulus("round_carry",   32'h3FFFFFFF, 32'h0A000000, 1'b0, 32'h40000000, 4'b0010, 4, 1'b1);
    applyStimulus("far_sticky",    32'h3E000000, 32'h02000000, 1'b0, 32'h3E000000, 4'b0010, 4, 1'b1);
    applyStimulus("neg_result",    32'h3E000000, 32'h40000000, 1'b1, 32'hBE000000, 4'b0001, 5, 1'b1);
    applyStimulus("plus_zero",     32'h3E000000, 32'h00000000, 1'b0, 32'h3E000000, 4'b0001, 4, 1'b1);
    waitDrain("directed");

    out_ready = 1'b0;
    applyStimulus("backpressure", 32'h3E000000, 32'h40000000, 1'b0, 32'h41000000, 4'b0001, 4, 1'b1);
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge clock100KHz); #1;
      guard++;
    end
    if (!out_valid) checkOutput("bp_valid_timeout", {31'b0, out_valid}, 32'd1);
    repeat (10) @(posedge clock100KHz);
    #1;
    out_ready = 1'b1;
    @(posedge clock100KHz); #1;
    checkOutput("bp_valid_drop", {31'b0, out_valid}, 32'd0);
    checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd1);

    applyStimulus("reset_in_norm", 32'h3E000001, 32'h3E000000, 1'b1, 32'h0, 4'b0, -1, 1'b0);
    repeat (8) @(posedge clock100KHz);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clock100KHz); #1;
    reset = 1'b1;
    repeat (40) @(posedge clock100KHz);
    #1;
    checkOutput("rst_idle_in_ready", {31'b0, in_ready}, 32'd1);

    applyStimulus("after_reset", 32'h3E000000, 32'h40000000, 1'b0, 32'h41000000, 4'b0001, 4, 1'b1);
    waitDrain("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
